// File: rtl/prefix_add_sequencer_pkg.sv
// Shared definitions for the limb-serial add/sub sequencer and its prefix16 datapath.
package prefix_add_sequencer_pkg;

    localparam int unsigned LIMB_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/prefix16.sv
// 16-bit Kogge-Stone prefix adder with carry in/out.
module prefix16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        c,
    output logic [15:0] s,
    output logic        cout
);

    logic [15:0] g [0:4];
    logic [15:0] p [0:4];
    logic [15:0] cin_vec;

    assign g[0] = x & y;
    assign p[0] = x ^ y;

    // Each level doubles the span of the group generate/propagate terms.
    for (genvar l = 0; l < 4; l++) begin : g_lvl
        for (genvar i = 0; i < 16; i++) begin : g_bit
            if (i >= (1 << l)) begin : g_comb
                assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-(1<<l)]);
                assign p[l+1][i] = p[l][i] & p[l][i-(1<<l)];
            end else begin : g_pass
                assign g[l+1][i] = g[l][i];
                assign p[l+1][i] = p[l][i];
            end
        end
    end

    assign cin_vec[0] = c;
    for (genvar i = 1; i < 16; i++) begin : g_carry
        assign cin_vec[i] = g[4][i-1] | (p[4][i-1] & c);
    end

    assign s    = p[0] ^ cin_vec;
    assign cout = g[4][15] | (p[4][15] & c);

endmodule

// File: rtl/prefix_add_sequencer.sv
// Arbitrates two requesters onto one prefix16 adder and runs wide add/sub
// one 16-bit limb per cycle, LS limb first.
module prefix_add_sequencer
    import prefix_add_sequencer_pkg::*;
#(
    parameter int unsigned LIMBS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req0_valid,
    output logic                       req0_ready,
    input  logic [LIMB_W*LIMBS-1:0]    req0_a,
    input  logic [LIMB_W*LIMBS-1:0]    req0_b,
    input  logic                       req0_sub,
    input  logic                       req1_valid,
    output logic                       req1_ready,
    input  logic [LIMB_W*LIMBS-1:0]    req1_a,
    input  logic [LIMB_W*LIMBS-1:0]    req1_b,
    input  logic                       req1_sub,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [LIMB_W*LIMBS-1:0]    rsp_sum,
    output logic                       rsp_cout,
    output logic                       rsp_id
);

    localparam int unsigned W     = LIMB_W * LIMBS;
    localparam int unsigned IDX_W = (LIMBS > 1) ? $clog2(LIMBS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LIMBS - 1);

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             sub_q, sub_d, id_q, id_d, carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic             gnt0, gnt1;
    logic [15:0]      add_x, add_y, add_s;
    logic             add_cout;

    assign gnt0 = req0_valid & (~req1_valid | (ptr_q == REQ0));
    assign gnt1 = req1_valid & (~req0_valid | (ptr_q == REQ1));

    assign add_x = a_q[idx_q*LIMB_W +: LIMB_W];
    assign add_y = sub_q ? ~b_q[idx_q*LIMB_W +: LIMB_W] : b_q[idx_q*LIMB_W +: LIMB_W];

    prefix16 u_prefix16 (
        .x    (add_x),
        .y    (add_y),
        .c    (carry_q),
        .s    (add_s),
        .cout (add_cout)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        a_d        = a_q;
        b_d        = b_q;
        sub_d      = sub_q;
        id_d       = id_q;
        carry_d    = carry_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                req0_ready = gnt0;
                req1_ready = gnt1;
                if (gnt0 | gnt1) begin
                    a_d     = gnt1 ? req1_a   : req0_a;
                    b_d     = gnt1 ? req1_b   : req0_b;
                    sub_d   = gnt1 ? req1_sub : req0_sub;
                    id_d    = gnt1 ? REQ1 : REQ0;
                    ptr_d   = gnt1 ? REQ0 : REQ1;
                    carry_d = gnt1 ? req1_sub : req0_sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*LIMB_W +: LIMB_W] = add_s;
                carry_d = add_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= REQ0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            id_q    <= REQ0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            id_q    <= id_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
        end
    end

    // The final limb's carry stays in carry_q through DONE, so it doubles as rsp_cout.
    assign rsp_sum  = sum_q;
    assign rsp_cout = carry_q;
    assign rsp_id   = id_q;

endmodule
